mult_ctrl: RTL

//  Sequencing FSM for the 32-bit shift-add multiplier datapath (regA/regB/regProd, add-select mux).

---
 rtl/mult_ctrl_if.sv | 25 ++
 rtl/mult_ctrl.sv | 104 ++++++++++
 2 files changed

// File: rtl/mult_ctrl_if.sv
// Start/done handshake plus datapath select/status lines between mult_ctrl and
// the shift-add multiplier datapath / requesting logic.
interface mult_ctrl_if;
  logic start;
  logic b_lsb;
  logic b_zero;
  logic a_sel;
  logic b_sel;
  logic prod_sel;
  logic add_sel;
  logic busy;
  logic done;

  // Controller side.
  modport slave (
    input  start, b_lsb, b_zero,
    output a_sel, b_sel, prod_sel, add_sel, busy, done
  );

  // Requester plus datapath side.
  modport master (
    output start, b_lsb, b_zero,
    input  a_sel, b_sel, prod_sel, add_sel, busy, done
  );
endinterface

// File: rtl/mult_ctrl.sv
// Sequencing FSM for the shift-add multiplier: IDLE -> RUN (SIZE iterations) -> DONE.
// Optional MUL_EARLY_EXIT_EN ends RUN as soon as the shifted multiplier is zero.
module mult_ctrl #(
  parameter int SIZE  = 32,
  parameter int CNT_W = $clog2(SIZE)
) (
  input  logic        clk,
  input  logic        reset,
  mult_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SIZE - 1);

  state_t           stateReg, stateNext;
  logic [CNT_W-1:0] cntReg, cntNext;

  logic aSel, bSel, prodSel, addSel, busyOut, doneOut;

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= IDLE;
      cntReg   <= '0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    aSel      = 1'b0;
    bSel      = 1'b0;
    prodSel   = 1'b1;
    addSel    = 1'b0;
    busyOut   = 1'b0;
    doneOut   = 1'b0;

    unique case (stateReg)
      IDLE: begin
        // Reset gating keeps the select lines at their idle values while reset is held.
        if (bus.start && !reset) begin
          prodSel   = 1'b0;
          cntNext   = '0;
          stateNext = RUN;
        end
      end

      RUN: begin
        aSel    = 1'b1;
        bSel    = 1'b1;
        busyOut = 1'b1;
        addSel  = bus.b_lsb;
        // Counter saturates at the last iteration rather than wrapping.
        if (cntReg != LAST_CNT) begin
          cntNext = cntReg + 1'b1;
        end
`ifdef MUL_EARLY_EXIT_EN
        if (bus.b_zero) begin
          addSel    = 1'b0;
          stateNext = DONE;
        end else if (cntReg == LAST_CNT) begin
          stateNext = DONE;
        end
`else
        if (cntReg == LAST_CNT) begin
          stateNext = DONE;
        end
`endif
      end

      DONE: begin
        aSel      = 1'b1;
        bSel      = 1'b1;
        busyOut   = 1'b1;
        doneOut   = 1'b1;
        stateNext = IDLE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

`ifndef MUL_EARLY_EXIT_EN
  logic unusedBZero;
  assign unusedBZero = bus.b_zero;
`endif

  assign bus.a_sel    = aSel;
  assign bus.b_sel    = bSel;
  assign bus.prod_sel = prodSel;
  assign bus.add_sel  = addSel;
  assign bus.busy     = busyOut;
  assign bus.done     = doneOut;

endmodule
